serial_adder_initiator: RTL

//  Requesting side of the serial-adder start/done protocol. Buffers operand pairs from the

---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/sa_cmd_fifo.sv | 64 ++++++
 rtl/serial_adder_initiator.sv | 135 +++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants and FSM encoding for the serial-adder initiator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_adder_pkg;

    localparam int OP_W_DEF  = 8;
    localparam int SUM_W_DEF = OP_W_DEF + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CAPT  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    // The sum keeps the full carry out of the top operand bit.
    function automatic int sum_width(input int op_w);
        return op_w + 1;
    endfunction

endpackage

// File: rtl/sa_cmd_fifo.sv
// Command FIFO holding packed {a,b} operand pairs for the initiator FSM.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: wr_ready = !full; pops on an empty FIFO are ignored.
module sa_cmd_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [W-1:0] wr_data,
    input  logic         rd_pop,
    output logic [W-1:0] rd_data,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          push;
    logic          pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign wr_ready = !full;
    assign push     = wr_valid && !full;
    assign pop      = rd_pop && !empty;
    assign rd_data  = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_adder_initiator.sv
// Queues operand pairs, runs them one at a time through a SerialAdder via start/done, holds the sum.
// Latency: push to res_valid = adder latency plus FIFO, issue, capture and result-register stages.
// Backpressure: cmd_ready = !fifo_full; a full result register stalls the FSM in CAPT. Optional SA_INIT_TIMEOUT_EN.
module serial_adder_initiator
    import serial_adder_pkg::*;
#(
    parameter int OP_W       = OP_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [OP_W-1:0]      cmd_a,
    input  logic [OP_W-1:0]      cmd_b,
    output logic [OP_W-1:0]      sa_a,
    output logic [OP_W-1:0]      sa_b,
    output logic                 sa_start,
    input  logic [OP_W:0]        sa_sum,
    input  logic                 sa_done,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [OP_W:0]        res_sum,
    output logic                 busy,
    output logic                 intr,
    output logic                 err
);

    localparam int SUM_W = sum_width(OP_W);

    state_t              state;
    logic [2*OP_W-1:0]   fifo_head;
    logic                fifo_empty;
    logic                fifo_pop;
    logic [SUM_W-1:0]    sum_hold;

`ifdef SA_INIT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]    tmo_cnt;
    logic                err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    sa_cmd_fifo #(
        .W     (2 * OP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (cmd_valid),
        .wr_ready (cmd_ready),
        .wr_data  ({cmd_a, cmd_b}),
        .rd_pop   (fifo_pop),
        .rd_data  (fifo_head),
        .empty    (fifo_empty)
    );

    assign fifo_pop = (state == S_IDLE) && !fifo_empty;
    assign busy     = (state != S_IDLE) || !fifo_empty;
    assign intr     = res_valid;

    // Protocol FSM plus result register. The sum is latched when done is seen so that
    // CAPT does not depend on the adder holding its output once start drops.
    // Later assignments in the case override the pop clear, so a capture wins over a pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            sa_start  <= 1'b0;
            sa_a      <= '0;
            sa_b      <= '0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            sum_hold  <= '0;
`ifdef SA_INIT_TIMEOUT_EN
            tmo_cnt   <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        sa_a  <= fifo_head[2*OP_W-1:OP_W];
                        sa_b  <= fifo_head[OP_W-1:0];
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    sa_start <= 1'b1;
`ifdef SA_INIT_TIMEOUT_EN
                    tmo_cnt  <= '0;
`endif
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (sa_done) begin
                        sa_start <= 1'b0;
                        sum_hold <= sa_sum;
                        state    <= S_CAPT;
                    end
`ifdef SA_INIT_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        sa_start  <= 1'b0;
                        err_q     <= 1'b1;
                        res_sum   <= '1;
                        res_valid <= 1'b1;
                        state     <= S_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                S_CAPT: begin
                    if (!res_valid || res_ready) begin
                        res_sum   <= sum_hold;
                        res_valid <= 1'b1;
                        state     <= S_GAP;
                    end
                end
                S_GAP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
